// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit: op encodings,
// FSM state type and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_datapath.sv
// One radix-2 iteration on the {acc, q} register pair: shift-add for
// multiply, restoring shift-subtract for divide.
module mdu_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum    = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : '0);
    rem    = {acc_i, q_i[WIDTH-1]};
    borrow = rem < {1'b0, b_i};
    // When no borrow the true difference is below the divisor, so the low bits suffice.
    diff   = rem[WIDTH-1:0] - b_i;
    if (is_div) begin
      if (borrow) begin
        acc_o = rem[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = diff;
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Signed MULT/DIV are built only when MDU_SIGNED_OPS_EN is defined.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             cancel,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       state_dbg
);

  // Handshake: start is taken only in IDLE or FINISH; busy is high for exactly
  // WIDTH cycles, then done pulses for one cycle with hi/lo already updated.
  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, qr_q, qr_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, div_zero_q, div_zero_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] dp_acc, dp_q, res_hi, res_lo, a_mag, b_mag;
  logic             op_div;
`ifdef MDU_SIGNED_OPS_EN
  logic             op_signed;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
`endif

  mdu_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .q_i    (qr_q),
    .b_i    (b_q),
    .acc_o  (dp_acc),
    .q_o    (dp_q)
  );

  always_comb begin
    op_div = (op == MDU_DIVU) || (op == MDU_DIV);
    a_mag  = srcA;
    b_mag  = srcB;
`ifdef MDU_SIGNED_OPS_EN
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    if (op_signed && srcA[WIDTH-1]) a_mag = -srcA;
    if (op_signed && srcB[WIDTH-1]) b_mag = -srcB;
`endif
  end

  // Final-iteration result with sign correction and divide-by-zero override.
  always_comb begin
    res_hi = dp_acc;
    res_lo = dp_q;
`ifdef MDU_SIGNED_OPS_EN
    if (is_div_q) begin
      if (neg_res_q) res_lo = -dp_q;
      if (neg_rem_q) res_hi = -dp_acc;
    end else if (neg_res_q) begin
      {res_hi, res_lo} = -{dp_acc, dp_q};
    end
`endif
    if (is_div_q && div_zero_q) res_lo = '1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qr_d       = qr_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
`ifdef MDU_SIGNED_OPS_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (start) begin
          state_d    = RUN;
          is_div_d   = op_div;
          div_zero_d = (srcB == '0);
          acc_d      = '0;
          qr_d       = op_div ? a_mag : b_mag;
          b_d        = op_div ? b_mag : a_mag;
`ifdef MDU_SIGNED_OPS_EN
          neg_res_d  = op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          neg_rem_d  = op_signed && op_div && srcA[WIDTH-1];
`endif
        end else begin
          if (hiWe) hi_d = wrData;
          if (loWe) lo_d = wrData;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = dp_acc;
          qr_d  = dp_q;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FINISH;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      qr_q       <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MDU_SIGNED_OPS_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qr_q       <= qr_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MDU_SIGNED_OPS_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: random and directed ops against an
// arithmetic reference model, with a queue-based result monitor.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, cancel, hiWe, loWe;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB, wrData;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  mdu_state_e   state_dbg;

  logic [2*W-1:0] exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;
  logic [W-1:0]   cur_hi = '0;
  logic [W-1:0]   cur_lo = '0;
  logic [2*W-1:0] pend;
  logic [W-1:0]   corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .cancel(cancel), .hiWe(hiWe), .loWe(loWe), .wrData(wrData),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on {hi, lo}.
  function automatic logic [2*W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit     sgn;
    longint sa, sb, q, r;
`ifdef MDU_SIGNED_OPS_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (!o[1]) begin
      q = sa * sb;
      return 64'(q);
    end
    if (b == '0) return {a, {W{1'b1}}};
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 20));
      default: return corners[$urandom_range(0, 4)];
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'(0));
      else check("result_hi_lo", {hi, lo}, exp_q.pop_front());
    end
  end

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic lw);
    start  = 1'b1;
    op     = o;
    srcA   = a;
    srcB   = b;
    loWe   = lw;
    wrData = 32'h1234_5678;
    pend   = ref_model(o, a, b);
    exp_q.push_back(pend);
  endtask

  // Waits for done, k0 cycles of the op having already elapsed.
  task automatic wait_done(input int k0);
    int k = k0;
    int nbusy = 0;
    bit seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      start = 1'b0; loWe = 1'b0; hiWe = 1'b0;
      srcA = $urandom; srcB = $urandom;
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    check("latency", 64'(k), 64'(33));
    check("busy_cycles", 64'(nbusy + k0), 64'(32));
    if (seen) begin
      check("busy_at_done", 64'(busy), 64'(0));
      {cur_hi, cur_lo} = pend;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    op = '0; srcA = '0; srcB = '0; wrData = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(IDLE));

    // Directed unsigned cases.
    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done(0);
    launch(MDU_DIVU, 32'd100, 32'd7, 1'b0);               wait_done(0);
    launch(MDU_DIVU, 32'd5, 32'd0, 1'b0);                 wait_done(0);
`ifdef MDU_SIGNED_OPS_EN
    launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);          wait_done(0);
    launch(MDU_MULT, 32'hFFFF_FFFD, 32'd4, 1'b0);         wait_done(0);
    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  wait_done(0);
    launch(MDU_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);          wait_done(0);
`endif

    // Cancel mid divide: no done, hi/lo keep their prior values.
    @(negedge clk);
    launch(MDU_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (10) begin @(negedge clk); start = 1'b0; end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    void'(exp_q.pop_back());
    check("cancel_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("cancel_hi", 64'(hi), 64'(cur_hi));
    check("cancel_lo", 64'(lo), 64'(cur_lo));

    // MTHI while busy is ignored.
    launch(MDU_MULTU, 32'd7, 32'd9, 1'b0);
    @(negedge clk); start = 1'b0; hiWe = 1'b1; wrData = 32'hDEAD_BEEF;
    @(negedge clk); hiWe = 1'b0;
    check("mthi_busy_ignored", 64'(hi), 64'(cur_hi));
    wait_done(2);

    // MTHI in idle, then both writes together.
    @(negedge clk); hiWe = 1'b1; wrData = 32'hDEAD_BEEF;
    @(negedge clk); hiWe = 1'b0;
    check("mthi_idle", 64'(hi), 64'(32'hDEAD_BEEF));
    check("mthi_lo_untouched", 64'(lo), 64'(cur_lo));
    cur_hi = 32'hDEAD_BEEF;
    hiWe = 1'b1; loWe = 1'b1; wrData = 32'hCAFE_F00D;
    @(negedge clk); hiWe = 1'b0; loWe = 1'b0;
    check("mthilo_hi", 64'(hi), 64'(32'hCAFE_F00D));
    check("mthilo_lo", 64'(lo), 64'(32'hCAFE_F00D));
    cur_hi = 32'hCAFE_F00D; cur_lo = 32'hCAFE_F00D;

    // start together with MTLO: op wins, write dropped.
    launch(MDU_DIVU, 32'd77, 32'd5, 1'b1);
    @(negedge clk); start = 1'b0; loWe = 1'b0;
    check("start_beats_mtlo", 64'(lo), 64'(cur_lo));
    check("start_busy", 64'(busy), 64'(1));
    wait_done(1);

    // Back-to-back: new start in the done cycle.
    launch(MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0); wait_done(0);
    launch(MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0);         wait_done(0);

    // Randomized ops, mixing back-to-back and idle gaps.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      launch(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
      wait_done(0);
    end

    // Reset mid-operation: registers clear, no done afterwards.
    @(negedge clk);
    launch(MDU_MULTU, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    repeat (5) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    check("midreset_hi", 64'(hi), 64'(0));
    check("midreset_lo", 64'(lo), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    void'(exp_q.pop_back());
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    check("post_reset_done", 64'(done), 64'(0));
    repeat (40) @(negedge clk);
    check("post_reset_idle", 64'(state_dbg), 64'(IDLE));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS execute stage.
- Sits beside the single-cycle ALU and is fed from the same srcA/srcB operand muxes.
- Owns the HI/LO registers, so MULT/MULTU/DIV/DIVU results and MTHI/MTLO writes land here; MFHI/MFLO read hi/lo directly.
- Multi-cycle via a start/busy/done handshake; the hazard unit stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  launch op this cycle; sampled only when idle
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- srcA  in  WIDTH  multiplicand / dividend
- srcB  in  WIDTH  multiplier / divisor
- cancel  in  1  pipeline flush; aborts an in-flight op
- hiWe  in  1  MTHI write enable
- loWe  in  1  MTLO write enable
- wrData  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, results committed
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation abandons the op; hi/lo go to 0.
- FSM: IDLE -> RUN on start; RUN -> FINISH after counter reaches WIDTH; FINISH -> IDLE unconditionally. cancel in RUN -> IDLE, no commit, no done.
- Timing, with start sampled at edge T:
  - busy=1 during cycles T+1..T+WIDTH.
  - FINISH cycle T+WIDTH+1: busy=0, done=1. hi/lo already hold the results, since they are written on the edge entering FINISH.
  - Total latency is WIDTH+1 = 33 cycles.
- Operands are latched at start. srcA/srcB may change afterwards without effect.
- start while busy=1 is ignored. start in the FINISH cycle is accepted, giving back-to-back ops.
- MULTU: radix-2 shift-add over WIDTH iterations. {hi,lo} = full 2*WIDTH-bit unsigned product.
- DIVU: radix-2 restoring division over WIDTH iterations. lo=quotient, hi=remainder.
- Divide by zero: the iterations still run. Commit lo={WIDTH{1}} and hi=dividend.
- MULT/DIV: see Optional Feature.
- hiWe/loWe:
  - Honoured only in IDLE or FINISH; hi<=wrData / lo<=wrData on that edge.
  - Ignored while busy.
  - If start and a write coincide, start wins and the write is dropped.
  - hiWe and loWe together write the same wrData to both registers.
- done is never asserted for a cancelled op or in the cycle after reset.

Optional Feature:
- Macro: MDU_SIGNED_OPS_EN.
- Defined:
  - op 01/11 operate signed. Operands are converted to magnitudes at start; sign is fixed in the final iteration.
  - Product is negated if srcA[31]^srcB[31].
  - Quotient sign is srcA[31]^srcB[31]; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Signed divide by zero: lo={WIDTH{1}}, hi=dividend.
- Undefined: op[0] is ignored, so MULT behaves as MULTU and DIV as DIVU. No sign logic is synthesized.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV
  - FSM state typedef: IDLE, RUN, FINISH
  - WIDTH default
- One sub-module, mdu_iter_datapath: per-iteration shift-add / restoring-subtract step on the {acc, q} register pair, selected by a mul/div bit.
- The top level holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- Reset, then start MULTU srcA=0xFFFFFFFF srcB=0xFFFFFFFF -> busy for 32 cycles; done at cycle 33 with hi=0xFFFFFFFE, lo=0x00000001.
- DIVU srcA=100 srcB=7 -> lo=14, hi=2. Then DIVU srcB=0, srcA=5 -> lo=0xFFFFFFFF, hi=5.
- With MDU_SIGNED_OPS_EN:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MULT -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU, assert cancel at cycle 10 -> busy drops next cycle, no done, hi/lo retain prior values.
- hiWe=1, wrData=0xDEADBEEF while busy -> hi unchanged. Same write in IDLE -> hi=0xDEADBEEF next cycle. start+loWe together -> op runs, lo write dropped.
- Back-to-back: new start in the done cycle -> second op accepted, done again 33 cycles later. Reset asserted mid-op -> hi=lo=0, busy=0, no done.
